// File: rtl/imem_write_arb_if.sv
// Port bundle for the imem port-A write arbiter: loader bytes, CPU stores, port A.
// No latency of its own; byte_ready and cpu_gnt carry the backpressure.
// Backpressure: requesters hold valid/req until byte_ready/cpu_gnt is seen.
interface imem_write_arb_if #(
    parameter int ADDR_W = 14
);
    logic              boot_en;
    logic              load_clear;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              imem_ena;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;
    logic [11:0]       words_loaded;
    logic              busy;

    modport master (
        output boot_en, load_clear, byte_valid, byte_data,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  byte_ready, cpu_gnt,
        input  imem_ena, imem_wea, imem_addra, imem_dina, words_loaded, busy
    );

    modport slave (
        input  boot_en, load_clear, byte_valid, byte_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output byte_ready, cpu_gnt,
        output imem_ena, imem_wea, imem_addra, imem_dina, words_loaded, busy
    );
endinterface

// File: rtl/imem_write_arb.sv
// Shares imem port A between the boot-loader byte stream and CPU stores.
// Latency: a write reaches port A one cycle after acceptance (registered outputs).
// Backpressure: byte_ready drops for the single loader WRITE cycle; cpu_gnt is low then too.
module imem_write_arb #(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BOOT_BASE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_write_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [ADDR_W-1:0] load_ptr;
    logic [11:0]       words_q;
    logic              ena_q;
    logic [3:0]        wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [31:0]       dina_q;
    logic              byte_acc;

    // A byte arriving with load_clear is refused rather than silently dropped.
    assign bus.byte_ready   = rst_n & bus.boot_en & ~bus.load_clear & (state != WRITE);
    assign byte_acc         = bus.byte_valid & bus.byte_ready;
    assign bus.cpu_gnt      = rst_n & bus.cpu_req & (state != WRITE) & (bus.cpu_we != 4'h0);
    assign bus.busy         = (state != IDLE);
    assign bus.words_loaded = words_q;
    assign bus.imem_ena     = ena_q;
    assign bus.imem_wea     = wea_q;
    assign bus.imem_addra   = addra_q;
    assign bus.imem_dina    = dina_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            word_buf <= 32'h0;
            load_ptr <= BOOT_BASE;
            words_q  <= 12'h0;
            ena_q    <= 1'b0;
            wea_q    <= 4'h0;
            addra_q  <= '0;
            dina_q   <= 32'h0;
        end else begin
            // Loader WRITE wins the port; load_clear cancels it outright.
            if (state == WRITE && !bus.load_clear) begin
                ena_q   <= 1'b1;
                wea_q   <= 4'hF;
                addra_q <= load_ptr;
                dina_q  <= word_buf;
            end else if (bus.cpu_gnt) begin
                ena_q   <= 1'b1;
                wea_q   <= bus.cpu_we;
                addra_q <= bus.cpu_addr;
                dina_q  <= bus.cpu_wdata;
            end else begin
                ena_q   <= 1'b0;
                wea_q   <= 4'h0;
            end

            if (bus.load_clear) begin
                state    <= IDLE;
                byte_cnt <= 2'd0;
                word_buf <= 32'h0;
                load_ptr <= BOOT_BASE;
                words_q  <= 12'h0;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_acc) begin
                            word_buf <= {24'h0, bus.byte_data};
                            byte_cnt <= 2'd1;
                            state    <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (!bus.boot_en) begin
                            state    <= IDLE;
                            byte_cnt <= 2'd0;
                            word_buf <= 32'h0;
                        end else if (byte_acc) begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3)
                                state <= WRITE;
                        end
                    end
                    WRITE: begin
                        load_ptr <= load_ptr + ADDR_W'(4);
                        if (words_q != 12'hFFF)
                            words_q <= words_q + 12'd1;
                        byte_cnt <= 2'd0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_write_arb.sv
module tb_imem_write_arb;
    localparam int ADDR_W = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    imem_write_arb_if #(.ADDR_W(ADDR_W)) ifa();
    imem_write_arb_if #(.ADDR_W(ADDR_W)) ifb();

    // Second instance (high BOOT_BASE) sees identical stimulus.
    assign ifb.boot_en    = ifa.boot_en;
    assign ifb.load_clear = ifa.load_clear;
    assign ifb.byte_valid = ifa.byte_valid;
    assign ifb.byte_data  = ifa.byte_data;
    assign ifb.cpu_req    = ifa.cpu_req;
    assign ifb.cpu_we     = ifa.cpu_we;
    assign ifb.cpu_addr   = ifa.cpu_addr;
    assign ifb.cpu_wdata  = ifa.cpu_wdata;

    imem_write_arb #(.ADDR_W(ADDR_W), .BOOT_BASE(14'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    imem_write_arb #(.ADDR_W(ADDR_W), .BOOT_BASE(14'h3FFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Reference model state for the randomized phase
    int          m_bytes = 0;
    int          m_words = 0;
    bit          m_pend_write = 1'b0;
    bit          m_cpu_pend = 1'b0;
    logic [31:0] m_wbuf = 32'h0;
    logic [31:0] exp_mem[int];
    logic [31:0] dut_mem[int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        ifa.byte_valid = 1'b1;
        ifa.byte_data  = d;
        for (int i = 0; i < 4 && !ok; i++) begin
            #1;
            ok = ifa.byte_ready;
            tick();
        end
        chk("byte_accept", 32'(ok), 32'd1);
        ifa.byte_valid = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // One randomized cycle: model predicts handshakes and port activity from
    // "the cycle after every 4th accepted byte is the loader's write cycle".
    task automatic rnd_cycle(input bit quiet);
        bit exp_write;
        bit exp_gnt;
        bit nxt;
        int key;
        logic [31:0] old;
        exp_write = m_pend_write;
        nxt = 1'b0;
        if (!quiet && !m_cpu_pend && $urandom_range(0, 2) == 0) begin
            ifa.cpu_we    = 4'($urandom_range(1, 15));
            ifa.cpu_addr  = 14'h2000 | (14'($urandom) & 14'h1FFC);
            ifa.cpu_wdata = $urandom;
            m_cpu_pend    = 1'b1;
        end
        ifa.cpu_req    = m_cpu_pend;
        ifa.byte_valid = quiet ? 1'b0 : ($urandom_range(0, 3) != 0);
        ifa.byte_data  = 8'($urandom);
        #1;
        exp_gnt = m_cpu_pend && !exp_write;
        chk("rnd_byte_ready", 32'(ifa.byte_ready), 32'(!exp_write));
        chk("rnd_cpu_gnt", 32'(ifa.cpu_gnt), 32'(exp_gnt));
        chk("rnd_busy", 32'(ifa.busy), 32'(exp_write || (m_bytes % 4 != 0)));
        if (ifa.byte_valid && !exp_write) begin
            m_wbuf[(m_bytes % 4) * 8 +: 8] = ifa.byte_data;
            m_bytes++;
            if (m_bytes % 4 == 0) begin
                exp_mem[m_words * 4] = m_wbuf;
                m_words++;
                nxt = 1'b1;
            end
        end
        if (exp_gnt) begin
            key = int'(ifa.cpu_addr);
            old = exp_mem.exists(key) ? exp_mem[key] : 32'h0;
            exp_mem[key] = merge(old, ifa.cpu_wdata, ifa.cpu_we);
            m_cpu_pend = 1'b0;
        end
        tick();
        chk("rnd_ena", 32'(ifa.imem_ena), 32'(exp_write || exp_gnt));
        if (ifa.imem_ena) begin
            key = int'(ifa.imem_addra);
            old = dut_mem.exists(key) ? dut_mem[key] : 32'h0;
            dut_mem[key] = merge(old, ifa.imem_dina, ifa.imem_wea);
        end
        m_pend_write = nxt;
    endtask

    initial begin
        logic [31:0] got;
        ifa.boot_en    = 1'b1;
        ifa.load_clear = 1'b0;
        ifa.byte_valid = 1'b1;
        ifa.byte_data  = 8'h00;
        ifa.cpu_req    = 1'b1;
        ifa.cpu_we     = 4'hF;
        ifa.cpu_addr   = '0;
        ifa.cpu_wdata  = 32'h0;
        #2;
        chk("rst_ena", 32'(ifa.imem_ena), 0);
        chk("rst_wea", 32'(ifa.imem_wea), 0);
        chk("rst_addra", 32'(ifa.imem_addra), 0);
        chk("rst_dina", ifa.imem_dina, 0);
        chk("rst_words", 32'(ifa.words_loaded), 0);
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_byte_ready", 32'(ifa.byte_ready), 0);
        chk("rst_cpu_gnt", 32'(ifa.cpu_gnt), 0);
        ifa.cpu_req    = 1'b0;
        ifa.byte_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ifa.load_clear = 1'b1;
        tick();
        ifa.load_clear = 1'b0;

        // Loader stream, also showing pointer wrap on the high-base instance
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        tick();
        chk("ld1_ena", 32'(ifa.imem_ena), 1);
        chk("ld1_wea", 32'(ifa.imem_wea), 32'hF);
        chk("ld1_addra", 32'(ifa.imem_addra), 32'h0000);
        chk("ld1_dina", ifa.imem_dina, 32'h12345678);
        chk("wrap1_addra", 32'(ifb.imem_addra), 32'h3FFC);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        tick();
        chk("ld2_addra", 32'(ifa.imem_addra), 32'h0004);
        chk("ld2_dina", ifa.imem_dina, 32'hDEADBEEF);
        chk("ld2_words", 32'(ifa.words_loaded), 2);
        chk("wrap2_addra", 32'(ifb.imem_addra), 32'h0000);
        chk("wrap2_ena", 32'(ifb.imem_ena), 1);

        // CPU request arriving during the loader write cycle
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        ifa.cpu_req   = 1'b1;
        ifa.cpu_we    = 4'b0011;
        ifa.cpu_addr  = 14'h0100;
        ifa.cpu_wdata = 32'h0000ABCD;
        #1;
        chk("arb_gnt_write", 32'(ifa.cpu_gnt), 0);
        chk("arb_busy_write", 32'(ifa.busy), 1);
        tick();
        chk("arb_gnt_next", 32'(ifa.cpu_gnt), 1);
        chk("arb_ld_addra", 32'(ifa.imem_addra), 32'h0008);
        chk("arb_ld_dina", ifa.imem_dina, 32'h44332211);
        tick();
        ifa.cpu_req = 1'b0;
        chk("arb_cpu_ena", 32'(ifa.imem_ena), 1);
        chk("arb_cpu_wea", 32'(ifa.imem_wea), 32'h3);
        chk("arb_cpu_addra", 32'(ifa.imem_addra), 32'h0100);
        chk("arb_cpu_dina", ifa.imem_dina, 32'h0000ABCD);
        tick();
        chk("idle_ena", 32'(ifa.imem_ena), 0);
        chk("idle_wea", 32'(ifa.imem_wea), 0);
        chk("idle_addra_hold", 32'(ifa.imem_addra), 32'h0100);

        // Partial word discarded by boot_en drop
        send_byte(8'hAA); send_byte(8'hBB);
        ifa.boot_en = 1'b0;
        tick();
        chk("abort_busy", 32'(ifa.busy), 0);
        ifa.boot_en = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        chk("abort_addra", 32'(ifa.imem_addra), 32'h000C);
        chk("abort_dina", ifa.imem_dina, 32'h04030201);
        chk("abort_words", 32'(ifa.words_loaded), 4);

        // Request without byte enables is never granted
        ifa.cpu_req = 1'b1;
        ifa.cpu_we  = 4'h0;
        #1;
        chk("we0_gnt", 32'(ifa.cpu_gnt), 0);
        tick();
        chk("we0_ena", 32'(ifa.imem_ena), 0);
        ifa.cpu_req = 1'b0;

        // load_clear with three bytes pending and a byte on the bus
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        ifa.load_clear = 1'b1;
        ifa.byte_valid = 1'b1;
        ifa.byte_data  = 8'h99;
        #1;
        chk("clr_byte_ready", 32'(ifa.byte_ready), 0);
        tick();
        ifa.load_clear = 1'b0;
        ifa.byte_valid = 1'b0;
        chk("clr_busy", 32'(ifa.busy), 0);
        chk("clr_ena", 32'(ifa.imem_ena), 0);
        chk("clr_words", 32'(ifa.words_loaded), 0);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        tick();
        chk("clr_next_ena", 32'(ifa.imem_ena), 1);
        chk("clr_next_addra", 32'(ifa.imem_addra), 32'h0000);
        chk("clr_next_dina", ifa.imem_dina, 32'h08070605);

        // Asynchronous reset while port A shows a write
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        tick();
        chk("mid_ena_before", 32'(ifa.imem_ena), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ena", 32'(ifa.imem_ena), 0);
        chk("mid_rst_wea", 32'(ifa.imem_wea), 0);
        chk("mid_rst_words", 32'(ifa.words_loaded), 0);
        chk("mid_rst_byte_ready", 32'(ifa.byte_ready), 0);
        tick();
        chk("mid_rst_hold_ena", 32'(ifa.imem_ena), 0);
        rst_n = 1'b1;
        send_byte(8'hD0); send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
        tick();
        chk("post_rst_addra", 32'(ifa.imem_addra), 32'h0000);
        chk("post_rst_dina", ifa.imem_dina, 32'hD3D2D1D0);

        // Randomized traffic against the reference model
        ifa.load_clear = 1'b1;
        tick();
        ifa.load_clear = 1'b0;
        for (int n = 0; n < 600; n++) rnd_cycle(1'b0);
        for (int n = 0; n < 4; n++) rnd_cycle(1'b1);
        chk("rnd_words", 32'(ifa.words_loaded), 32'(m_words));
        chk("rnd_mem_entries", 32'(dut_mem.num()), 32'(exp_mem.num()));
        foreach (exp_mem[k]) begin
            got = dut_mem.exists(k) ? dut_mem[k] : 32'hxxxxxxxx;
            chk($sformatf("rnd_mem_%0h", k), got, exp_mem[k]);
        end

        // words_loaded saturation
        ifa.cpu_req    = 1'b0;
        ifa.load_clear = 1'b1;
        tick();
        ifa.load_clear = 1'b0;
        ifa.byte_valid = 1'b1;
        ifa.byte_data  = 8'h5A;
        repeat (20600) @(posedge clk);
        #1;
        ifa.byte_valid = 1'b0;
        chk("sat_words", 32'(ifa.words_loaded), 32'hFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
